soc_bus_decoder: RTL



---
 rtl/soc_bus_decoder_if.sv | 47 ++++
 rtl/soc_bus_decoder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/soc_bus_decoder_if.sv
// Bus bundle between the cpu6 data port, the decoder and its slaves.
// The "slave" modport is the decoder's view: it is the slave of the cpu6 data port and drives the shared slave bus.
// The "master" modport is the surrounding system: the cpu6 core plus the peripherals.
interface soc_bus_decoder_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ERRCNT_W   = 8
);

  // cpu6 data port
  logic                       m_req;
  logic                       m_we;
  logic [XLEN-1:0]            m_addr;
  logic [XLEN-1:0]            m_wdata;
  logic [XLEN-1:0]            m_rdata;
  logic                       m_ready;
  logic                       m_err;

  // shared slave bus
  logic [NUM_SLAVES-1:0]      s_req;
  logic                       s_we;
  logic [XLEN-1:0]            s_addr;
  logic [XLEN-1:0]            s_wdata;
  logic [NUM_SLAVES*XLEN-1:0] s_rdata;
  logic [NUM_SLAVES-1:0]      s_ready;

  // error capture
  logic [XLEN-1:0]            err_addr;
  logic [ERRCNT_W-1:0]        err_count;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    output m_rdata, m_ready, m_err,
    output s_req, s_we, s_addr, s_wdata,
    input  s_rdata, s_ready,
    output err_addr, err_count
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    input  m_rdata, m_ready, m_err,
    input  s_req, s_we, s_addr, s_wdata,
    output s_rdata, s_ready,
    input  err_addr, err_count
  );

endinterface

// File: rtl/soc_bus_decoder.sv
// Memory-mapped data-bus decoder: routes each cpu6 access to one of NUM_SLAVES
// address regions, waits for the slave's ready with a timeout, and returns a
// registered one-cycle response. Decode misses and timeouts complete with
// m_err and are recorded in err_addr / err_count.
module soc_bus_decoder #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SEL_LSB    = 16,
  parameter int unsigned SEL_BITS   = 2,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned ERRCNT_W   = 8
) (
  input  logic               clk,
  input  logic               resetn,
  soc_bus_decoder_if.slave   bus
);

  // Timer only has to hold 0..TIMEOUT-1.
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // One extra bit so NUM_SLAVES == 2^SEL_BITS is representable in the range check.
  localparam int unsigned SEL_CMP_W = SEL_BITS + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [SEL_BITS-1:0]   sel_q, sel_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic                  we_q, we_d;
  logic [XLEN-1:0]       addr_q, addr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [NUM_SLAVES-1:0] s_req_q, s_req_d;
  logic                  m_ready_q, m_ready_d;
  logic                  m_err_q, m_err_d;
  logic [XLEN-1:0]       m_rdata_q, m_rdata_d;
  logic [XLEN-1:0]       err_addr_q, err_addr_d;
  logic [ERRCNT_W-1:0]   err_count_q, err_count_d;

  logic [SEL_BITS-1:0]   sel_in_c;
  logic                  sel_in_range_c;
  logic                  sel_ready_c;
  logic [XLEN-1:0]       sel_rdata_c;

  // Slave-select field of the incoming address and whether it maps to a port.
  always_comb begin
    sel_in_c       = bus.m_addr[SEL_LSB +: SEL_BITS];
    sel_in_range_c = (SEL_CMP_W'(sel_in_c) < SEL_CMP_W'(NUM_SLAVES));
  end

  // Ready/read-data mux of the latched slave; other slaves' s_ready is ignored.
  always_comb begin
    sel_ready_c = 1'b0;
    sel_rdata_c = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_BITS'(i)) begin
        sel_ready_c = bus.s_ready[i];
        sel_rdata_c = bus.s_rdata[i*XLEN +: XLEN];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    timer_d     = timer_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    s_req_d     = '0;
    m_ready_d   = 1'b0;
    m_err_d     = 1'b0;
    m_rdata_d   = '0;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;

    case (state_q)
      S_IDLE: begin
        if (bus.m_req) begin
          sel_d   = sel_in_c;
          we_d    = bus.m_we;
          addr_d  = bus.m_addr;
          wdata_d = bus.m_wdata;
          timer_d = '0;
          state_d = sel_in_range_c ? S_BUSY : S_ERR;
        end
      end
      S_BUSY: begin
        // A ready on the last allowed cycle still completes normally.
        if (sel_ready_c) begin
          state_d   = S_RESP;
          m_rdata_d = we_q ? '0 : sel_rdata_c;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Request to the selected slave for every cycle spent in BUSY.
    if (state_d == S_BUSY) begin
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
        s_req_d[i] = (sel_d == SEL_BITS'(i));
      end
    end

    // Response pulse and error capture coincide with the RESP/ERR cycle.
    if (state_d == S_RESP) begin
      m_ready_d = 1'b1;
    end
    if (state_d == S_ERR) begin
      m_ready_d  = 1'b1;
      m_err_d    = 1'b1;
      err_addr_d = addr_d;
      if (err_count_q != '1) begin
        err_count_d = err_count_q + ERRCNT_W'(1);
      end
    end
  end

  // State, latches and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      timer_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      s_req_q     <= '0;
      m_ready_q   <= 1'b0;
      m_err_q     <= 1'b0;
      m_rdata_q   <= '0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      timer_q     <= timer_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      s_req_q     <= s_req_d;
      m_ready_q   <= m_ready_d;
      m_err_q     <= m_err_d;
      m_rdata_q   <= m_rdata_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  // Drive the bus from registers only.
  assign bus.s_req     = s_req_q;
  assign bus.s_we      = we_q;
  assign bus.s_addr    = addr_q;
  assign bus.s_wdata   = wdata_q;
  assign bus.m_ready   = m_ready_q;
  assign bus.m_err     = m_err_q;
  assign bus.m_rdata   = m_rdata_q;
  assign bus.err_addr  = err_addr_q;
  assign bus.err_count = err_count_q;

endmodule
